// File: rtl/bp_cce_lite_if.sv
// LCE request/response/command channels, BedRock memory channels and status of bp_cce_lite.
interface bp_cce_lite_if #(
  parameter int paddr_width_p  = 40,
  parameter int lce_id_width_p = 4,
  parameter int cce_id_width_p = 4,
  parameter int block_width_p  = 512
);
  localparam int lce_req_header_width_lp  = 9 + lce_id_width_p + paddr_width_p;
  localparam int lce_resp_header_width_lp = 2 + lce_id_width_p + paddr_width_p;
  localparam int lce_cmd_header_width_lp  = 10 + cce_id_width_p + lce_id_width_p + paddr_width_p;
  localparam int mem_header_width_lp      = 5 + paddr_width_p;

  logic [cce_id_width_p-1:0]           cce_id_i;
  logic [lce_req_header_width_lp-1:0]  lce_req_header_i;
  logic [block_width_p-1:0]            lce_req_data_i;
  logic                                lce_req_v_i;
  logic                                lce_req_yumi_o;
  logic [lce_resp_header_width_lp-1:0] lce_resp_header_i;
  logic [block_width_p-1:0]            lce_resp_data_i;
  logic                                lce_resp_v_i;
  logic                                lce_resp_yumi_o;
  logic [lce_cmd_header_width_lp-1:0]  lce_cmd_header_o;
  logic [block_width_p-1:0]            lce_cmd_data_o;
  logic                                lce_cmd_v_o;
  logic                                lce_cmd_ready_and_i;
  logic [mem_header_width_lp-1:0]      mem_cmd_header_o;
  logic [block_width_p-1:0]            mem_cmd_data_o;
  logic                                mem_cmd_v_o;
  logic                                mem_cmd_ready_and_i;
  logic [mem_header_width_lp-1:0]      mem_resp_header_i;
  logic [block_width_p-1:0]            mem_resp_data_i;
  logic                                mem_resp_v_i;
  logic                                mem_resp_yumi_o;
  logic                                sync_done_o;
  logic                                error_o;

  modport slave (
    input  cce_id_i,
    input  lce_req_header_i, lce_req_data_i, lce_req_v_i,
    output lce_req_yumi_o,
    input  lce_resp_header_i, lce_resp_data_i, lce_resp_v_i,
    output lce_resp_yumi_o,
    output lce_cmd_header_o, lce_cmd_data_o, lce_cmd_v_o,
    input  lce_cmd_ready_and_i,
    output mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o,
    input  mem_cmd_ready_and_i,
    input  mem_resp_header_i, mem_resp_data_i, mem_resp_v_i,
    output mem_resp_yumi_o,
    output sync_done_o, error_o
  );

  modport master (
    output cce_id_i,
    output lce_req_header_i, lce_req_data_i, lce_req_v_i,
    input  lce_req_yumi_o,
    output lce_resp_header_i, lce_resp_data_i, lce_resp_v_i,
    input  lce_resp_yumi_o,
    input  lce_cmd_header_o, lce_cmd_data_o, lce_cmd_v_o,
    output lce_cmd_ready_and_i,
    input  mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o,
    output mem_cmd_ready_and_i,
    output mem_resp_header_i, mem_resp_data_i, mem_resp_v_i,
    input  mem_resp_yumi_o,
    input  sync_done_o, error_o
  );
endinterface

// File: rtl/bp_cce_lite.sv
// Single-outstanding home-side CCE for bp_lce: boot sync, block fills in E/S,
// uncached loads/stores and LCE writebacks over the BedRock memory channel.
module bp_cce_lite #(
  parameter int paddr_width_p  = 40,
  parameter int lce_id_width_p = 4,
  parameter int cce_id_width_p = 4,
  parameter int num_lce_p      = 1,
  parameter int block_width_p  = 512,
  parameter int max_timeout_p  = 1024
) (
  input  logic         clk_i,
  input  logic         reset_i,
  bp_cce_lite_if.slave bus
);
  localparam int P = paddr_width_p;
  localparam int L = lce_id_width_p;
  localparam int blk_off_lp = $clog2(block_width_p / 8);
  localparam logic [2:0] blk_size_lp = 3'(blk_off_lp);
  localparam int timer_w_lp = $clog2(max_timeout_p + 1);
  localparam logic [timer_w_lp-1:0] timer_max_lp = timer_w_lp'(max_timeout_p);
  localparam logic [timer_w_lp-1:0] timer_one_lp = timer_w_lp'(1);
  localparam logic [L-1:0] last_lce_lp = L'(num_lce_p - 1);
  localparam logic [L-1:0] lce_one_lp  = L'(1);

  localparam logic [1:0] e_req_rd = 2'd0, e_req_wr = 2'd1, e_req_uc_rd = 2'd2, e_req_uc_wr = 2'd3;
  localparam logic [1:0] e_resp_sync_ack = 2'd0, e_resp_coh_ack = 2'd1,
                         e_resp_wb = 2'd2, e_resp_null_wb = 2'd3;
  localparam logic [1:0] e_bedrock_cmd_sync = 2'd0, e_bedrock_cmd_st_data = 2'd1,
                         e_bedrock_cmd_uc_data = 2'd2, e_bedrock_cmd_uc_st_done = 2'd3;
  localparam logic [1:0] e_coh_i = 2'd0, e_coh_s = 2'd1, e_coh_e = 2'd2;
  localparam logic [1:0] e_bedrock_mem_rd = 2'd0, e_bedrock_mem_wr = 2'd1;

  typedef enum logic [3:0] {
    e_sync_send, e_sync_ack, e_ready, e_mem_rd, e_mem_wait,
    e_send_cmd, e_wait_ack, e_mem_wr, e_mem_wr_ack
  } state_e;

  state_e state, state_n;

  logic [1:0]   req_type;
  logic [2:0]   req_size;
  logic         req_non_excl;
  logic [2:0]   req_way;
  logic [L-1:0] req_lce;
  logic [P-1:0] req_addr;
  assign {req_type, req_size, req_non_excl, req_way, req_lce, req_addr} = bus.lce_req_header_i;

  logic [1:0]   resp_type;
  logic [L-1:0] resp_lce_unused;
  logic [P-1:0] resp_addr;
  assign {resp_type, resp_lce_unused, resp_addr} = bus.lce_resp_header_i;

  logic [1:0]   mem_resp_type;
  logic [2:0]   mem_resp_size_unused;
  logic [P-1:0] mem_resp_addr_unused;
  assign {mem_resp_type, mem_resp_size_unused, mem_resp_addr_unused} = bus.mem_resp_header_i;

  logic [L-1:0]              lce_cnt;
  logic                      sync_done, error;
  logic [timer_w_lp-1:0]     timer;
  logic [1:0]                req_type_r;
  logic [2:0]                size_r, way_r;
  logic                      non_excl_r, wb_r;
  logic [L-1:0]              lce_id_r;
  logic [P-1:0]              addr_r;
  logic [block_width_p-1:0]  data_r;

  logic req_yumi, resp_yumi, mem_resp_yumi, cmd_v, mem_cmd_v;
  logic take_wb, sync_ack_ok, resp_err, mem_err, timeout, cached_r;
  logic [1:0] cmd_type, cmd_state, mem_type;

  function automatic logic [P-1:0] block_align(input logic [P-1:0] a);
    logic [P-1:0] mask;
    mask = '1;
    return a & (mask << blk_off_lp);
  endfunction

  assign cached_r  = (req_type_r == e_req_rd) || (req_type_r == e_req_wr);
  assign cmd_state = !cached_r ? e_coh_i : (non_excl_r ? e_coh_s : e_coh_e);
  assign timeout   = (timer == timer_max_lp);

  always_comb begin
    state_n       = state;
    req_yumi      = 1'b0;
    resp_yumi     = 1'b0;
    mem_resp_yumi = 1'b0;
    cmd_v         = 1'b0;
    mem_cmd_v     = 1'b0;
    cmd_type      = e_bedrock_cmd_sync;
    mem_type      = e_bedrock_mem_rd;
    take_wb       = 1'b0;
    sync_ack_ok   = 1'b0;
    resp_err      = 1'b0;
    mem_err       = 1'b0;
    case (state)
      e_sync_send: begin
        cmd_v = 1'b1;
        if (bus.lce_cmd_ready_and_i) state_n = e_sync_ack;
      end
      e_sync_ack: if (bus.lce_resp_v_i) begin
        resp_yumi = 1'b1;
        if (resp_type == e_resp_sync_ack) begin
          sync_ack_ok = 1'b1;
          state_n = (lce_cnt == last_lce_lp) ? e_ready : e_sync_send;
        end else begin
          resp_err = 1'b1;
        end
      end
      // Writebacks drain ahead of new requests so the LCE can free its victim.
      e_ready: begin
        if (bus.lce_resp_v_i) begin
          resp_yumi = 1'b1;
          case (resp_type)
            e_resp_wb: begin
              take_wb = 1'b1;
              state_n = e_mem_wr;
            end
            e_resp_null_wb: begin end
            default: resp_err = 1'b1;
          endcase
        end else if (sync_done && bus.lce_req_v_i) begin
          req_yumi = 1'b1;
          state_n  = (req_type == e_req_uc_wr) ? e_mem_wr : e_mem_rd;
        end
      end
      e_mem_rd: begin
        mem_cmd_v = 1'b1;
        if (bus.mem_cmd_ready_and_i) state_n = e_mem_wait;
      end
      e_mem_wait: begin
        if (bus.mem_resp_v_i) begin
          mem_resp_yumi = 1'b1;
          mem_err = (mem_resp_type != e_bedrock_mem_rd);
          state_n = e_send_cmd;
        end
        if (bus.lce_resp_v_i) begin
          resp_yumi = 1'b1;
          resp_err  = 1'b1;
        end
      end
      e_send_cmd: begin
        cmd_v    = 1'b1;
        cmd_type = cached_r ? e_bedrock_cmd_st_data :
                   (req_type_r == e_req_uc_rd) ? e_bedrock_cmd_uc_data : e_bedrock_cmd_uc_st_done;
        if (bus.lce_cmd_ready_and_i) state_n = cached_r ? e_wait_ack : e_ready;
      end
      e_wait_ack: if (bus.lce_resp_v_i) begin
        resp_yumi = 1'b1;
        if (resp_type == e_resp_coh_ack) state_n = e_ready;
        else resp_err = 1'b1;
      end
      e_mem_wr: begin
        mem_cmd_v = 1'b1;
        mem_type  = e_bedrock_mem_wr;
        if (bus.mem_cmd_ready_and_i) state_n = e_mem_wr_ack;
      end
      e_mem_wr_ack: begin
        if (bus.mem_resp_v_i) begin
          mem_resp_yumi = 1'b1;
          mem_err = (mem_resp_type != e_bedrock_mem_wr);
          state_n = wb_r ? e_ready : e_send_cmd;
        end
        if (bus.lce_resp_v_i) begin
          resp_yumi = 1'b1;
          resp_err  = 1'b1;
        end
      end
      default: state_n = e_sync_send;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= e_sync_send;
      lce_cnt   <= '0;
      sync_done <= 1'b0;
      error     <= 1'b0;
      timer     <= '0;
    end else begin
      state <= state_n;
      if (sync_ack_ok) begin
        if (lce_cnt == last_lce_lp) sync_done <= 1'b1;
        else lce_cnt <= lce_cnt + lce_one_lp;
      end
      if (resp_err || mem_err || timeout) error <= 1'b1;
      // Idle is not a wait; the timer only saturates, it never aborts the FSM.
      if (state_n != state) timer <= '0;
      else if (state != e_ready && !timeout) timer <= timer + timer_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take_wb) begin
      wb_r   <= 1'b1;
      addr_r <= block_align(resp_addr);
      size_r <= blk_size_lp;
      data_r <= bus.lce_resp_data_i;
    end else if (req_yumi) begin
      wb_r       <= 1'b0;
      req_type_r <= req_type;
      non_excl_r <= req_non_excl;
      way_r      <= req_way;
      lce_id_r   <= req_lce;
      if (req_type == e_req_rd || req_type == e_req_wr) begin
        addr_r <= block_align(req_addr);
        size_r <= blk_size_lp;
      end else begin
        addr_r <= req_addr;
        size_r <= req_size;
      end
      if (req_type == e_req_uc_wr) data_r <= bus.lce_req_data_i;
    end else if (mem_resp_yumi && state == e_mem_wait) begin
      data_r <= bus.mem_resp_data_i;
    end
  end

  assign bus.lce_req_yumi_o   = req_yumi & ~reset_i;
  assign bus.lce_resp_yumi_o  = resp_yumi & ~reset_i;
  assign bus.mem_resp_yumi_o  = mem_resp_yumi & ~reset_i;
  assign bus.lce_cmd_v_o      = cmd_v & ~reset_i;
  assign bus.mem_cmd_v_o      = mem_cmd_v & ~reset_i;
  assign bus.lce_cmd_header_o = (state == e_sync_send)
    ? {e_bedrock_cmd_sync, e_coh_i, 3'd0, 3'd0, bus.cce_id_i, lce_cnt, {P{1'b0}}}
    : {cmd_type, cmd_state, way_r, size_r, bus.cce_id_i, lce_id_r, addr_r};
  assign bus.lce_cmd_data_o   = data_r;
  assign bus.mem_cmd_header_o = {mem_type, size_r, addr_r};
  assign bus.mem_cmd_data_o   = data_r;
  assign bus.sync_done_o      = sync_done;
  assign bus.error_o          = error;
endmodule

// File: tb/tb_bp_cce_lite.sv
// Directed bench for bp_cce_lite: sync, fills, uncached ops, writebacks, backpressure, errors.
module tb_bp_cce_lite;
  localparam int P = 32;
  localparam int L = 4;
  localparam int C = 4;
  localparam int BW = 128;
  localparam logic [3:0] CCE_ID = 4'h5;
  localparam logic [2:0] BLK = 3'd4;

  localparam logic [1:0] REQ_RD = 0, REQ_UC_RD = 2, REQ_UC_WR = 3;
  localparam logic [1:0] RESP_SYNC = 0, RESP_COH = 1, RESP_WB = 2, RESP_NULL = 3;
  localparam logic [1:0] CMD_SYNC = 0, CMD_ST = 1, CMD_UC = 2, CMD_DONE = 3;
  localparam logic [1:0] ST_I = 0, ST_S = 1, ST_E = 2;
  localparam logic [1:0] MEM_RD = 0, MEM_WR = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_cce_lite_if #(.paddr_width_p(P), .lce_id_width_p(L), .cce_id_width_p(C),
                   .block_width_p(BW)) bus ();

  bp_cce_lite #(.paddr_width_p(P), .lce_id_width_p(L), .cce_id_width_p(C), .num_lce_p(2),
                .block_width_p(BW), .max_timeout_p(32))
    dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  function automatic logic [49:0] mk_cmd(input logic [1:0] t, input logic [1:0] st,
      input logic [2:0] way, input logic [2:0] sz, input logic [3:0] dst, input logic [31:0] a);
    return {t, st, way, sz, CCE_ID, dst, a};
  endfunction

  function automatic logic [36:0] mk_mem(input logic [1:0] t, input logic [2:0] sz,
      input logic [31:0] a);
    return {t, sz, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [49:0] hdr, input bit chk_data,
      input logic [127:0] data);
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.lce_cmd_v_o) begin seen = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_v"}, bus.lce_cmd_v_o, 1);
    if (seen) begin
      chk({tag, "_hdr"}, bus.lce_cmd_header_o, hdr);
      if (chk_data) chk({tag, "_data"}, bus.lce_cmd_data_o, data);
    end
    @(negedge clk);
  endtask

  task automatic expect_mem(input string tag, input logic [36:0] hdr, input bit chk_data,
      input logic [127:0] data);
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.mem_cmd_v_o) begin seen = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_v"}, bus.mem_cmd_v_o, 1);
    if (seen) begin
      chk({tag, "_hdr"}, bus.mem_cmd_header_o, hdr);
      if (chk_data) chk({tag, "_data"}, bus.mem_cmd_data_o, data);
    end
    @(negedge clk);
  endtask

  task automatic mem_respond(input string tag, input logic [1:0] t, input logic [127:0] data);
    bus.mem_resp_header_i = mk_mem(t, BLK, 32'h0);
    bus.mem_resp_data_i   = data;
    bus.mem_resp_v_i      = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.mem_resp_yumi_o) break;
      @(negedge clk);
    end
    chk({tag, "_yumi"}, bus.mem_resp_yumi_o, 1);
    @(negedge clk);
    bus.mem_resp_v_i = 1'b0;
  endtask

  task automatic send_resp(input string tag, input logic [1:0] t, input logic [3:0] lce,
      input logic [31:0] a, input logic [127:0] data);
    bus.lce_resp_header_i = {t, lce, a};
    bus.lce_resp_data_i   = data;
    bus.lce_resp_v_i      = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.lce_resp_yumi_o) break;
      @(negedge clk);
    end
    chk({tag, "_yumi"}, bus.lce_resp_yumi_o, 1);
    @(negedge clk);
    bus.lce_resp_v_i = 1'b0;
  endtask

  task automatic send_req(input string tag, input logic [1:0] t, input logic [2:0] sz,
      input logic ne, input logic [2:0] way, input logic [3:0] lce, input logic [31:0] a,
      input logic [127:0] data, output int yumi_cyc);
    bus.lce_req_header_i = {t, sz, ne, way, lce, a};
    bus.lce_req_data_i   = data;
    bus.lce_req_v_i      = 1'b1;
    yumi_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.lce_req_yumi_o) begin yumi_cyc = cyc; break; end
      @(negedge clk);
    end
    chk({tag, "_yumi"}, bus.lce_req_yumi_o, 1);
    @(negedge clk);
    bus.lce_req_v_i = 1'b0;
  endtask

  task automatic do_sync();
    for (int i = 0; i < 2; i++) begin
      expect_cmd($sformatf("sync_cmd%0d", i), mk_cmd(CMD_SYNC, ST_I, 3'd0, 3'd0, 4'(i), 32'h0),
                 1'b0, '0);
      chk($sformatf("sync_done_pre%0d", i), bus.sync_done_o, 0);
      send_resp($sformatf("sync_ack%0d", i), RESP_SYNC, 4'(i), 32'h0, '0);
    end
    chk("sync_done", bus.sync_done_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_yumi;
    logic [127:0] d_fill, d_wb, d_rd2, d_uc;
    d_fill = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d_wb   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d_rd2  = 128'hCAFE_F00D_0000_0001_0000_0002_BEEF_0003;
    d_uc   = 128'h0000_0000_0000_0000_0000_0000_A5A5_5A5A;
    bus.cce_id_i = CCE_ID;
    bus.lce_req_header_i = '0;  bus.lce_req_data_i = '0;  bus.lce_req_v_i = 1'b0;
    bus.lce_resp_header_i = '0; bus.lce_resp_data_i = '0; bus.lce_resp_v_i = 1'b0;
    bus.lce_cmd_ready_and_i = 1'b1;
    bus.mem_cmd_ready_and_i = 1'b1;
    bus.mem_resp_header_i = '0; bus.mem_resp_data_i = '0; bus.mem_resp_v_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_v", bus.lce_cmd_v_o, 0);
    chk("rst_mem_v", bus.mem_cmd_v_o, 0);
    chk("rst_sync_done", bus.sync_done_o, 0);
    chk("rst_error", bus.error_o, 0);
    rst = 1'b0;

    do_sync();

    // cached read miss: block fill in E, 3-cycle req-to-cmd latency
    send_req("rd", REQ_RD, 3'd6, 1'b0, 3'd3, 4'd0, 32'h8000_0040, '0, t_yumi);
    expect_mem("rd_mem", mk_mem(MEM_RD, BLK, 32'h8000_0040), 1'b0, '0);
    mem_respond("rd_mresp", MEM_RD, d_fill);
    chk("rd_latency", 32'(cyc - t_yumi), 32'd3);
    expect_cmd("rd_fill", mk_cmd(CMD_ST, ST_E, 3'd3, BLK, 4'd0, 32'h8000_0040), 1'b1, d_fill);
    send_resp("rd_ack", RESP_COH, 4'd0, 32'h8000_0040, '0);
    #1 chk("rd_idle_mem", bus.mem_cmd_v_o, 0);
    chk("rd_idle_cmd", bus.lce_cmd_v_o, 0);
    @(negedge clk);

    // uncached store
    send_req("ucw", REQ_UC_WR, 3'd3, 1'b0, 3'd0, 4'd0, 32'h1000_0008, 128'hDEAD_BEEF, t_yumi);
    expect_mem("ucw_mem", mk_mem(MEM_WR, 3'd3, 32'h1000_0008), 1'b1, 128'hDEAD_BEEF);
    mem_respond("ucw_mresp", MEM_WR, '0);
    expect_cmd("ucw_done", mk_cmd(CMD_DONE, ST_I, 3'd0, 3'd3, 4'd0, 32'h1000_0008), 1'b0, '0);

    // null writeback: consumed without memory traffic
    send_resp("nullwb", RESP_NULL, 4'd0, 32'h0, '0);
    #1 chk("nullwb_mem", bus.mem_cmd_v_o, 0);
    @(negedge clk);

    // uncached load
    send_req("ucr", REQ_UC_RD, 3'd2, 1'b0, 3'd0, 4'd1, 32'h5000_0004, '0, t_yumi);
    expect_mem("ucr_mem", mk_mem(MEM_RD, 3'd2, 32'h5000_0004), 1'b0, '0);
    mem_respond("ucr_mresp", MEM_RD, d_uc);
    expect_cmd("ucr_data", mk_cmd(CMD_UC, ST_I, 3'd0, 3'd2, 4'd1, 32'h5000_0004), 1'b1, d_uc);

    // writeback and request together: writeback first
    bus.lce_resp_header_i = {RESP_WB, 4'd0, 32'h2000_0018};
    bus.lce_resp_data_i   = d_wb;
    bus.lce_resp_v_i      = 1'b1;
    bus.lce_req_header_i  = {REQ_RD, 3'd4, 1'b1, 3'd1, 4'd0, 32'h3000_0000};
    bus.lce_req_v_i       = 1'b1;
    #1 chk("wb_resp_yumi", bus.lce_resp_yumi_o, 1);
    chk("wb_req_held", bus.lce_req_yumi_o, 0);
    @(negedge clk);
    bus.lce_resp_v_i = 1'b0;
    #1 chk("wb_req_held2", bus.lce_req_yumi_o, 0);
    expect_mem("wb_mem", mk_mem(MEM_WR, BLK, 32'h2000_0010), 1'b1, d_wb);
    mem_respond("wb_mresp", MEM_WR, '0);
    #1 chk("wb_then_req_yumi", bus.lce_req_yumi_o, 1);
    @(negedge clk);
    bus.lce_req_v_i = 1'b0;
    expect_mem("rd2_mem", mk_mem(MEM_RD, BLK, 32'h3000_0000), 1'b0, '0);

    // command backpressure: header/data stable, no duplicate
    bus.lce_cmd_ready_and_i = 1'b0;
    mem_respond("rd2_mresp", MEM_RD, d_rd2);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("hold%0d_v", i), bus.lce_cmd_v_o, 1);
      chk($sformatf("hold%0d_hdr", i), bus.lce_cmd_header_o,
          mk_cmd(CMD_ST, ST_S, 3'd1, BLK, 4'd0, 32'h3000_0000));
      chk($sformatf("hold%0d_data", i), bus.lce_cmd_data_o, d_rd2);
      @(negedge clk);
    end
    bus.lce_cmd_ready_and_i = 1'b1;
    expect_cmd("rd2_fill", mk_cmd(CMD_ST, ST_S, 3'd1, BLK, 4'd0, 32'h3000_0000), 1'b1, d_rd2);
    #1 chk("rd2_no_second", bus.lce_cmd_v_o, 0);
    @(negedge clk);
    send_resp("rd2_ack", RESP_COH, 4'd0, 32'h3000_0000, '0);
    chk("no_error_yet", bus.error_o, 0);

    // coh_ack while waiting on memory
    send_req("rd3", REQ_RD, 3'd4, 1'b0, 3'd2, 4'd1, 32'h4000_0048, '0, t_yumi);
    expect_mem("rd3_mem", mk_mem(MEM_RD, BLK, 32'h4000_0040), 1'b0, '0);
    send_resp("early_ack", RESP_COH, 4'd1, 32'h4000_0040, '0);
    chk("early_ack_error", bus.error_o, 1);
    mem_respond("rd3_mresp", MEM_RD, d_fill);
    expect_cmd("rd3_fill", mk_cmd(CMD_ST, ST_E, 3'd2, BLK, 4'd1, 32'h4000_0040), 1'b1, d_fill);
    send_resp("rd3_ack", RESP_COH, 4'd1, 32'h4000_0040, '0);
    chk("error_sticky", bus.error_o, 1);

    rst = 1'b1;
    #1 chk("rst2_error", bus.error_o, 0);
    chk("rst2_sync_done", bus.sync_done_o, 0);
    chk("rst2_cmd_v", bus.lce_cmd_v_o, 0);
    @(negedge clk);
    rst = 1'b0;
    do_sync();

    // withheld coh_ack -> timeout
    send_req("rd4", REQ_RD, 3'd4, 1'b0, 3'd0, 4'd0, 32'h8000_0080, '0, t_yumi);
    expect_mem("rd4_mem", mk_mem(MEM_RD, BLK, 32'h8000_0080), 1'b0, '0);
    mem_respond("rd4_mresp", MEM_RD, d_rd2);
    expect_cmd("rd4_fill", mk_cmd(CMD_ST, ST_E, 3'd0, BLK, 4'd0, 32'h8000_0080), 1'b1, d_rd2);
    repeat (20) @(negedge clk);
    chk("timeout_not_yet", bus.error_o, 0);
    repeat (20) @(negedge clk);
    chk("timeout_error", bus.error_o, 1);
    send_resp("late_ack", RESP_COH, 4'd0, 32'h8000_0080, '0);
    chk("timeout_sticky", bus.error_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
